// File: rtl/fpaddsub_pkg.sv
// Shared definitions for the FP add/sub output stage: flag bit positions
// and the skid buffer state encoding.
package fpaddsub_pkg;

  // Number of IEEE exception flags carried with each result
  localparam int FLAG_NUM = 5;

  // Flag bit positions inside the flag vector
  localparam int FLAG_OVF = 4;
  localparam int FLAG_UNF = 3;
  localparam int FLAG_DBZ = 2;
  localparam int FLAG_INV = 1;
  localparam int FLAG_INX = 0;

  // Occupancy of the 2-entry skid buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/fpaddsub_skid_buf.sv
// Two-entry skid buffer for result word + flags.
// The head entry drives the outputs directly. The tail entry catches the
// one input accepted while the head is stalled, which lets in_ready come
// straight from a flop instead of from out_ready.
module fpaddsub_skid_buf
  import fpaddsub_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FLAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_z,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_z,
  output logic [FLAG_W-1:0] out_flags,
  output logic              accept
);

  localparam int PAY_W = DATA_W + FLAG_W;

  skid_state_e      state;
  logic [PAY_W-1:0] head;
  logic [PAY_W-1:0] tail;
  logic [PAY_W-1:0] din;
  logic             deliver;

  assign din     = {in_z, in_flags};
  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  assign out_z     = head[PAY_W-1:FLAG_W];
  assign out_flags = head[FLAG_W-1:0];

  // Occupancy FSM; in_ready and out_valid are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      head      <= '0;
      tail      <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            head      <= din;
            state     <= ST_ONE;
            out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !deliver) begin
            tail     <= din;
            state    <= ST_TWO;
            in_ready <= 1'b0;
          end else if (accept && deliver) begin
            head <= din;
          end else if (deliver) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (deliver) begin
            head     <= tail;
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fpaddsub_output_stage.sv
// Output stage of the FP add/sub pipeline: registered handshake buffer for
// the result word and its exception flags, plus an optional sticky status
// register accumulating the flags of every accepted result.
// Build option: define FPADDSUB_STICKY_FLAGS_EN to build the sticky
// register; otherwise sticky_flags reads 0 and clr_sticky is ignored.
module fpaddsub_output_stage
  import fpaddsub_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FLAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_z,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_z,
  output logic [FLAG_W-1:0] out_flags,
  input  logic              clr_sticky,
  output logic [FLAG_W-1:0] sticky_flags
);

  logic accept;

  fpaddsub_skid_buf #(
    .DATA_W (DATA_W),
    .FLAG_W (FLAG_W)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z      (in_z),
    .in_flags  (in_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_flags (out_flags),
    .accept    (accept)
  );

`ifdef FPADDSUB_STICKY_FLAGS_EN
  logic [FLAG_W-1:0] sticky;

  // Clear wipes prior history only; flags accepted in the same cycle survive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky <= '0;
    end else begin
      sticky <= (clr_sticky ? '0 : sticky) | (accept ? in_flags : '0);
    end
  end

  assign sticky_flags = sticky;
`else
  logic unused_sticky_inputs;

  assign unused_sticky_inputs = &{1'b0, clr_sticky, accept};
  assign sticky_flags         = '0;
`endif

endmodule

// File: doc/fpaddsub_output_stage.md
FPADDSUB_OUTPUT_STAGE -- requirements
Module: fpaddsub_output_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the result word Z.
REQ-002 SHALL have parameter FLAG_W, default 5, width of the flag vector {Overflow, Underflow, DivideByZero, Invalid, Inexact}.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream result Z/Flags valid this cycle.
REQ-006 SHALL have port in_ready  output  1  stage can accept an input this cycle.
REQ-007 SHALL have port in_z  input  DATA_W  result word from the exception stage.
REQ-008 SHALL have port in_flags  input  FLAG_W  exception flags accompanying in_z.
REQ-009 SHALL have port out_valid  output  1  out_z/out_flags hold a result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-011 SHALL have port out_z  output  DATA_W  buffered result word.
REQ-012 SHALL have port out_flags  output  FLAG_W  flags of the result on out_z.
REQ-013 SHALL have port clr_sticky  input  1  synchronous clear of the sticky status register.
REQ-014 SHALL have port sticky_flags  output  FLAG_W  accumulated OR of flags of all accepted results.

Function
REQ-015 SHALL accept an input when in_valid & in_ready, and deliver an output when out_valid & out_ready.
REQ-016 SHALL be a 2-entry skid buffer with states EMPTY, ONE, TWO: EMPTY->ONE on accept; ONE->TWO on accept without deliver; ONE->EMPTY on deliver without accept; ONE stays ONE on simultaneous accept and deliver; TWO->ONE on deliver.
REQ-017 SHALL drive in_ready from a register only: in_ready = 1 in EMPTY and ONE, 0 in TWO; in_ready SHALL NOT depend combinationally on out_ready.
REQ-018 SHALL drive out_valid, out_z and out_flags from registers; out_valid = 1 in ONE and TWO.
REQ-019 SHALL have latency of exactly one cycle from accept to out_valid when the buffer is EMPTY.
REQ-020 SHALL deliver results in strict acceptance order, with no loss or duplication.
REQ-021 SHALL hold out_z/out_flags stable while out_valid & ~out_ready.
REQ-022 SHALL update sticky_flags each cycle as: sticky_next = (clr_sticky ? 0 : sticky) | (accept ? in_flags : 0).
REQ-023 SHALL retain the accepted flags when clr_sticky and an accept coincide; the clear applies to prior history only.
REQ-024 SHALL ignore in_z/in_flags when in_valid = 0, and SHALL ignore in_valid while in_ready = 0.
REQ-025 SHALL sustain one result per cycle when out_ready is held high.

Reset
REQ-026 SHALL, on rst, force state EMPTY, in_ready 1, out_valid 0, out_z 0, out_flags 0 and sticky_flags 0, asynchronously.
REQ-027 SHALL discard any buffered results when rst is asserted mid-operation; the first accept after reset release behaves as from EMPTY.

Configuration
REQ-028 SHALL use macro FPADDSUB_STICKY_FLAGS_EN: when defined, the sticky register per REQ-022/023 is built; when undefined, sticky_flags is tied to 0, clr_sticky is ignored, and no sticky flops exist.

Structure
REQ-029 SHALL take flag bit indices (OVF=4, UNF=3, DBZ=2, INV=1, INX=0) and the state encoding from a shared package, fpaddsub_pkg.
REQ-030 SHALL contain one sub-module, fpaddsub_skid_buf, holding the 2-entry buffer and FSM; the sticky logic lives in the top level.

Verification
REQ-031 SHALL cover: reset, then one input Z=0x3F800000, flags=0 with out_ready=1 -> out_valid one cycle later with out_z=0x3F800000, then EMPTY.
REQ-032 SHALL cover: out_ready=0, three consecutive in_valid -> first two accepted, in_ready=0 in the third cycle; out_ready=1 -> outputs delivered in order, then in_ready=1.
REQ-033 SHALL cover: accept flags 5'b10001, then 5'b00010 -> sticky_flags=5'b10011; clr_sticky with an accept of 5'b00100 -> sticky_flags=5'b00100.
REQ-034 SHALL cover: continuous in_valid and out_ready for 100 cycles with incrementing Z -> 100 outputs with no bubbles after the first.
REQ-035 SHALL cover: rst asserted while in TWO -> out_valid=0, in_ready=1 and sticky_flags=0 immediately, with no stale output after release.
REQ-036 SHALL cover: build without FPADDSUB_STICKY_FLAGS_EN and accept flags 5'b11111 -> sticky_flags stays 0.
